// File: rtl/axi_slave_mem_bridge_if.sv
// Simplified AXI user bus between the slave front-end and the memory bridge.
// Carries the AW/W/B write channels and the AR/R read channels.
// The slave modport is the bridge side and the master modport is the front-end side.
interface axi_slave_mem_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  awvalid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic                  bvalid;
    logic                  bready;

    logic                  arvalid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awvalid, awaddr, awlen, wdata, wlast, wvalid, bready,
        input  arvalid, araddr, arlen, rready,
        output awready, wready, bvalid, arready, rdata, rlast, rvalid
    );

    modport master (
        output awvalid, awaddr, awlen, wdata, wlast, wvalid, bready,
        output arvalid, araddr, arlen, rready,
        input  awready, wready, bvalid, arready, rdata, rlast, rvalid
    );
endinterface

// File: rtl/axi_slave_mem_bridge.sv
// Serves simplified AXI INCR bursts from one single-port synchronous memory,
// one beat per cycle, with one burst in flight at a time.
// Optional macro USER_MEM_OUTREG_EN: the memory has an output register
// (2-cycle read latency), and the read buffer grows to 3 entries.
//
//   state | meaning
//   IDLE  | awready=1, arready=!awvalid; waits for a burst request
//   WRITE | wready=1; each wvalid cycle writes one word
//   WRESP | bvalid=1 until bready
//   READ  | issues reads under credit, streams the returned data out
module axi_slave_mem_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    axi_slave_mem_bridge_if.slave     s_axi,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic                      mem_we,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
`ifdef USER_MEM_OUTREG_EN
    localparam int MEM_LAT  = 2;
    localparam int RD_DEPTH = 3;
`else
    localparam int MEM_LAT  = 1;
    localparam int RD_DEPTH = 2;
`endif
    localparam int CNT_W = $clog2(RD_DEPTH + 1);
    localparam int PTR_W = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic [8:0]                r_beats;

    logic [MEM_LAT-1:0]        r_pipe_vld;
    logic [MEM_LAT-1:0]        r_pipe_last;

    logic [DATA_WIDTH-1:0]     r_fifo_data [RD_DEPTH];
    logic                      r_fifo_last [RD_DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [CNT_W-1:0]          r_count;

    logic                      w_aw_hs;
    logic                      w_ar_hs;
    logic                      w_wbeat;
    logic                      w_issue;
    logic                      w_issue_last;
    logic                      w_ret;
    logic                      w_ret_last;
    logic [CNT_W-1:0]          w_inflight;
    logic [CNT_W:0]            w_occ;
    logic                      w_fifo_empty;
    logic                      w_rvalid;
    logic [DATA_WIDTH-1:0]     w_head_data;
    logic                      w_head_last;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_fifo_pop;

    assign w_aw_hs      = (r_state == IDLE) && s_axi.awvalid;
    assign w_ar_hs      = (r_state == IDLE) && !s_axi.awvalid && s_axi.arvalid;
    assign w_wbeat      = (r_state == WRITE) && s_axi.wvalid;

    // Returned read data arrives MEM_LAT cycles after its address was issued.
    assign w_ret        = r_pipe_vld[MEM_LAT-1];
    assign w_ret_last   = r_pipe_last[MEM_LAT-1];

    // Count reads still travelling through the memory pipeline, including the one returning now.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            w_inflight = w_inflight + CNT_W'(r_pipe_vld[i]);
        end
    end

    // Credit check: everything in flight plus everything buffered must fit in the buffer.
    assign w_occ        = (CNT_W+1)'(w_inflight) + (CNT_W+1)'(r_count);
    assign w_issue_last = (r_beats == 9'd1);
    assign w_issue      = (r_state == READ) && (r_beats != 9'd0) &&
                          (w_occ < (CNT_W+1)'(RD_DEPTH));

    // Empty buffer: the returning word bypasses straight to the R channel to save a cycle.
    assign w_fifo_empty = (r_count == '0);
    assign w_rvalid     = !w_fifo_empty || w_ret;
    assign w_head_data  = w_fifo_empty ? mem_rdata  : r_fifo_data[r_rd_ptr];
    assign w_head_last  = w_fifo_empty ? w_ret_last : r_fifo_last[r_rd_ptr];
    assign w_pop        = w_rvalid && s_axi.rready;
    assign w_push       = w_ret && !(w_fifo_empty && w_pop);
    assign w_fifo_pop   = w_pop && !w_fifo_empty;

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic; write wins over read in IDLE, and write ends by beat count only.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_aw_hs)      w_state_nxt = WRITE;
                else if (w_ar_hs) w_state_nxt = READ;
            end
            WRITE: if (w_wbeat && (r_beats == 9'd1)) w_state_nxt = WRESP;
            WRESP: if (s_axi.bready)                 w_state_nxt = IDLE;
            READ:  if (w_pop && w_head_last)         w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs; the ready signals are held low while in reset.
    always_comb begin
        s_axi.awready = ARESETN && (r_state == IDLE);
        s_axi.arready = ARESETN && (r_state == IDLE) && !s_axi.awvalid;
        s_axi.wready  = (r_state == WRITE);
        s_axi.bvalid  = (r_state == WRESP);
        mem_we        = w_wbeat;
    end

    assign mem_addr     = r_addr;
    assign mem_wdata    = ARESETN ? s_axi.wdata : '0;
    assign s_axi.rvalid = w_rvalid;
    assign s_axi.rdata  = w_rvalid ? w_head_data : '0;
    assign s_axi.rlast  = w_rvalid && w_head_last;

    // Burst address and remaining-beat counter; the address wraps modulo the memory depth.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_addr  <= '0;
            r_beats <= '0;
        end else if (w_aw_hs) begin
            r_addr  <= MEM_ADDR_WIDTH'(s_axi.awaddr >> BYTE_SHIFT);
            r_beats <= {1'b0, s_axi.awlen} + 9'd1;
        end else if (w_ar_hs) begin
            r_addr  <= MEM_ADDR_WIDTH'(s_axi.araddr >> BYTE_SHIFT);
            r_beats <= {1'b0, s_axi.arlen} + 9'd1;
        end else if (w_wbeat || w_issue) begin
            r_addr  <= r_addr + MEM_ADDR_WIDTH'(1);
            r_beats <= r_beats - 9'd1;
        end
    end

    // Track issued reads and their last flag through the memory latency.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_pipe_vld  <= '0;
            r_pipe_last <= '0;
        end else begin
            r_pipe_vld[0]  <= w_issue;
            r_pipe_last[0] <= w_issue && w_issue_last;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
            end
        end
    end

    // Read buffer pointers and fill count; reset flushes it.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == PTR_W'(RD_DEPTH-1)) ? '0 : r_wr_ptr + PTR_W'(1);
            if (w_fifo_pop)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(RD_DEPTH-1)) ? '0 : r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_fifo_pop);
        end
    end

    // Read buffer storage; contents are qualified by the count, so no reset is needed.
    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= mem_rdata;
            r_fifo_last[r_wr_ptr] <= w_ret_last;
        end
    end

    // wlast does not steer the burst, but it must agree with the beat count.
    a_wlast_matches_count: assert property (
        @(posedge ACLK) disable iff (!ARESETN)
        w_wbeat |-> (s_axi.wlast == (r_beats == 9'd1))
    );

endmodule

// File: tb/tb_axi_slave_mem_bridge.sv
// Directed bench for axi_slave_mem_bridge with a behavioural single-port memory.
module tb_axi_slave_mem_bridge;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAW = 10;
`ifdef USER_MEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    logic [MAW-1:0] mem_addr;
    logic           mem_we;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;

    axi_slave_mem_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_slave_mem_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MAW)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(bus),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 ACLK = ~ACLK;

    logic [DW-1:0] mem     [0:1023];
    logic [DW-1:0] exp_mem [0:1023];
    logic [DW-1:0] rd_q1, rd_q2;

    always @(posedge ACLK) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        rd_q1 <= mem[mem_addr];
        rd_q2 <= rd_q1;
    end
    assign mem_rdata = (LAT == 2) ? rd_q2 : rd_q1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic write_burst(input logic [31:0] addr, input int len, input logic [31:0] d0,
                               input int bdelay, input bit ar_blocked);
        logic [MAW-1:0] w0;
        w0 = MAW'(addr >> 2);
        bus.awvalid = 1'b1; bus.awaddr = addr; bus.awlen = 8'(len);
        @(negedge ACLK);
        check("awready", bus.awready, 1);
        if (ar_blocked) check("arready_blocked", bus.arready, 0);
        @(posedge ACLK); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bus.wvalid = 1'b1; bus.wdata = d0 + 32'(i); bus.wlast = (i == len);
            @(negedge ACLK);
            check("wready", bus.wready, 1);
            check("mem_we", mem_we, 1);
            check("mem_addr_w", mem_addr, MAW'(w0 + MAW'(i)));
            check("mem_wdata", mem_wdata, d0 + 32'(i));
            check("bvalid_early", bus.bvalid, 0);
            exp_mem[MAW'(w0 + MAW'(i))] = d0 + 32'(i);
            @(posedge ACLK); #1;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        for (int k = 0; k < bdelay; k++) begin
            @(negedge ACLK);
            check("bvalid_hold", bus.bvalid, 1);
            check("mem_we_resp", mem_we, 0);
            if (ar_blocked) check("arready_in_wresp", bus.arready, 0);
            @(posedge ACLK); #1;
        end
        bus.bready = 1'b1;
        @(negedge ACLK);
        check("bvalid", bus.bvalid, 1);
        @(posedge ACLK); #1;
        bus.bready = 1'b0;
    endtask

    // mode 0: rready always high; mode 1: rready 1,0,0 repeating.
    task automatic read_burst(input logic [31:0] addr, input int len, input int mode);
        logic [MAW-1:0] w0;
        int idx, cyc, first_cyc, last_cyc;
        bit stalled;
        logic [DW-1:0] held_d;
        logic held_l;
        w0 = MAW'(addr >> 2);
        bus.arvalid = 1'b1; bus.araddr = addr; bus.arlen = 8'(len);
        @(negedge ACLK);
        check("arready", bus.arready, 1);
        @(posedge ACLK); #1;
        bus.arvalid = 1'b0;
        idx = 0; cyc = 1; first_cyc = -1; last_cyc = 0; stalled = 1'b0;
        held_d = '0; held_l = 1'b0;
        while (idx <= len && cyc < 100) begin
            bus.rready = (mode == 0) ? 1'b1 : (cyc % 3 == 2);
            @(negedge ACLK);
            if (bus.rvalid) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    check("first_rvalid_latency", cyc, LAT + 1);
                end
                if (stalled) begin
                    check("rdata_stable", bus.rdata, held_d);
                    check("rlast_stable", bus.rlast, held_l);
                end
                check("rdata", bus.rdata, exp_mem[MAW'(w0 + MAW'(idx))]);
                check("rlast", bus.rlast, (idx == len));
                if (bus.rready) begin
                    last_cyc = cyc; idx++; stalled = 1'b0;
                end else begin
                    stalled = 1'b1; held_d = bus.rdata; held_l = bus.rlast;
                end
            end else if (stalled) begin
                check("rvalid_stalled", bus.rvalid, 1);
                stalled = 1'b0;
            end
            @(posedge ACLK); #1;
            cyc++;
        end
        bus.rready = 1'b0;
        check("read_beats", idx, len + 1);
        if (mode == 0) check("stream_cycles", last_cyc - first_cyc, len);
        @(negedge ACLK);
        check("rvalid_after_burst", bus.rvalid, 0);
        check("idle_after_read", bus.awready, 1);
        @(posedge ACLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got3;
        int idx;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0; exp_mem[i] = '0;
        end
        bus.awvalid = 1'b1; bus.awaddr = '0; bus.awlen = '0;
        bus.wdata = 32'hDEAD_BEEF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
        bus.bready = 1'b0; bus.arvalid = 1'b1; bus.araddr = '0; bus.arlen = '0;
        bus.rready = 1'b1;

        // Outputs while in reset, with requests active on every input.
        #12;
        check("rst_awready", bus.awready, 0);
        check("rst_arready", bus.arready, 0);
        check("rst_wready", bus.wready, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_rlast", bus.rlast, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        bus.awvalid = 1'b0; bus.arvalid = 1'b0; bus.wvalid = 1'b0;
        bus.wdata = '0; bus.rready = 1'b0;
        @(negedge ACLK); ARESETN = 1'b1;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        check("idle_awready", bus.awready, 1);
        check("idle_arready", bus.arready, 1);
        @(posedge ACLK); #1;

        // Write then read back: words 0x40..0x43.
        write_burst(32'h100, 3, 32'hA0, 0, 1'b0);
        read_burst(32'h100, 3, 0);

        // Wrap-around at the top of the memory.
        write_burst(32'hFF8, 3, 32'hC0, 1, 1'b0);
        read_burst(32'hFF8, 3, 1);

        // Single-beat bursts with a delayed bready.
        write_burst(32'h200, 0, 32'h55, 5, 1'b0);
        read_burst(32'h200, 0, 0);

        // Eight-beat read with backpressure, then full-rate streaming.
        write_burst(32'h400, 7, 32'h10, 0, 1'b0);
        read_burst(32'h400, 7, 1);
        read_burst(32'h400, 7, 0);

        // Simultaneous AW and AR: write first, read after the B handshake.
        bus.arvalid = 1'b1; bus.araddr = 32'h100; bus.arlen = 8'd3;
        write_burst(32'h800, 1, 32'hE0, 2, 1'b1);
        read_burst(32'h100, 3, 0);

        // Reset while the third beat of an eight-beat read is presented.
        bus.arvalid = 1'b1; bus.araddr = 32'h400; bus.arlen = 8'd7;
        @(negedge ACLK);
        check("arready_rst_test", bus.arready, 1);
        @(posedge ACLK); #1;
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        got3 = 1'b0; idx = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge ACLK);
            if (bus.rvalid) begin
                if (idx == 2) begin
                    got3 = 1'b1;
                    break;
                end
                idx++;
            end
        end
        check("beat3_reached", got3, 1);
        check("beat3_data", bus.rdata, 32'h12);
        ARESETN = 1'b0;
        #1;
        check("rst_mid_rvalid", bus.rvalid, 0);
        check("rst_mid_awready", bus.awready, 0);
        check("rst_mid_arready", bus.arready, 0);
        check("rst_mid_mem_we", mem_we, 0);
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        check("awready_after_rst", bus.awready, 1);
        check("rvalid_after_rst", bus.rvalid, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge ACLK);
            check("no_rvalid_post_rst", bus.rvalid, 0);
            check("no_bvalid_post_rst", bus.bvalid, 0);
        end
        @(posedge ACLK); #1;
        bus.rready = 1'b0;
        read_burst(32'h404, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
